mem_burst_arbiter: RTL

MEM_BURST_ARBITER -- requirements
Module: mem_burst_arbiter

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_burst_arbiter_rr_pick.sv | 24 ++
 rtl/mem_burst_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-channel memory burst arbiter: slot encoding,
// FSM state encoding and parameter defaults.
package mem_arb_pkg;

    localparam int MEM_DATA_BITS_DEF = 64;
    localparam int ADDR_BITS_DEF     = 24;
    localparam int LEN_BITS_DEF      = 10;
    localparam int WDOG_CYCLES_DEF   = 65535;

    localparam logic [1:0] SLOT_CH0_WR = 2'd0;
    localparam logic [1:0] SLOT_CH0_RD = 2'd1;
    localparam logic [1:0] SLOT_CH1_WR = 2'd2;
    localparam logic [1:0] SLOT_CH1_RD = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    // Bit 0 of a slot is the direction, bit 1 the channel.
    function automatic logic slot_is_read(input logic [1:0] slot);
        return slot[0];
    endfunction

    function automatic logic slot_chan(input logic [1:0] slot);
        return slot[1];
    endfunction

endpackage

// File: rtl/mem_burst_arbiter_rr_pick.sv
// Combinational 4-way round-robin priority encoder: the search starts at
// last+1 (mod 4) and the first active request wins.
module rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);

    always_comb begin
        logic [1:0] cand;
        valid = 1'b0;
        idx   = last;
        cand  = '0;
        for (int i = 1; i <= 4; i++) begin
            cand = last + 2'(i);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_burst_arbiter.sv
// Two-channel read/write burst arbiter in front of a single memory controller.
// Optional burst watchdog is enabled by defining MEM_ARB_WDOG_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no burst; requests are sampled and a slot picked
// ST_ISSUE | first cycle of the granted burst, memory request raised
// ST_BUSY  | burst running; waits for the granted direction's finish
module mem_burst_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_DATA_BITS = MEM_DATA_BITS_DEF,
    parameter int ADDR_BITS     = ADDR_BITS_DEF,
    parameter int LEN_BITS      = LEN_BITS_DEF,
    parameter int WDOG_CYCLES   = WDOG_CYCLES_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 wr_burst_req,
    input  logic [2*LEN_BITS-1:0]      wr_burst_len,
    input  logic [2*ADDR_BITS-1:0]     wr_burst_addr,
    input  logic [2*MEM_DATA_BITS-1:0] wr_burst_data,
    output logic [1:0]                 wr_burst_data_req,
    output logic [1:0]                 wr_burst_finish,
    input  logic [1:0]                 rd_burst_req,
    input  logic [2*LEN_BITS-1:0]      rd_burst_len,
    input  logic [2*ADDR_BITS-1:0]     rd_burst_addr,
    output logic [1:0]                 rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0]   rd_burst_data,
    output logic [1:0]                 rd_burst_finish,
    output logic                       mem_wr_burst_req,
    output logic [LEN_BITS-1:0]        mem_wr_burst_len,
    output logic [ADDR_BITS-1:0]       mem_wr_burst_addr,
    output logic [MEM_DATA_BITS-1:0]   mem_wr_burst_data,
    input  logic                       mem_wr_burst_data_req,
    input  logic                       mem_wr_burst_finish,
    output logic                       mem_rd_burst_req,
    output logic [LEN_BITS-1:0]        mem_rd_burst_len,
    output logic [ADDR_BITS-1:0]       mem_rd_burst_addr,
    input  logic                       mem_rd_burst_data_valid,
    input  logic                       mem_rd_burst_finish,
    input  logic [MEM_DATA_BITS-1:0]   mem_rd_burst_data,
    output logic [1:0]                 grant_id,
    output logic                       busy,
    output logic                       arb_timeout
);

    logic [1:0]           state;
    logic [1:0]           last_grant;
    logic [3:0]           req_vec;
    logic                 pick_valid;
    logic [1:0]           pick_idx;
    logic [LEN_BITS-1:0]  pick_len;
    logic [ADDR_BITS-1:0] pick_addr;
    logic [LEN_BITS-1:0]  burst_len;
    logic [ADDR_BITS-1:0] burst_addr;
    logic                 gnt_rd;
    logic                 gnt_ch;
    logic                 data_strobe;
    logic                 fin_hit;
    logic                 wdog_hit;
    logic                 done;

    assign req_vec = {rd_burst_req[1], wr_burst_req[1], rd_burst_req[0], wr_burst_req[0]};

    rr_pick u_rr_pick (
        .req   (req_vec),
        .last  (last_grant),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        pick_len  = wr_burst_len[LEN_BITS-1:0];
        pick_addr = wr_burst_addr[ADDR_BITS-1:0];
        case (pick_idx)
            SLOT_CH0_WR: begin
                pick_len  = wr_burst_len[LEN_BITS-1:0];
                pick_addr = wr_burst_addr[ADDR_BITS-1:0];
            end
            SLOT_CH0_RD: begin
                pick_len  = rd_burst_len[LEN_BITS-1:0];
                pick_addr = rd_burst_addr[ADDR_BITS-1:0];
            end
            SLOT_CH1_WR: begin
                pick_len  = wr_burst_len[2*LEN_BITS-1:LEN_BITS];
                pick_addr = wr_burst_addr[2*ADDR_BITS-1:ADDR_BITS];
            end
            SLOT_CH1_RD: begin
                pick_len  = rd_burst_len[2*LEN_BITS-1:LEN_BITS];
                pick_addr = rd_burst_addr[2*ADDR_BITS-1:ADDR_BITS];
            end
            default: ;
        endcase
    end

    assign gnt_rd      = slot_is_read(grant_id);
    assign gnt_ch      = slot_chan(grant_id);
    assign data_strobe = gnt_rd ? mem_rd_burst_data_valid : mem_wr_burst_data_req;
    // Finish only counts in BUSY and only from the granted direction.
    assign fin_hit     = (state == ST_BUSY) && (gnt_rd ? mem_rd_burst_finish : mem_wr_burst_finish);
    assign done        = fin_hit || wdog_hit;
    assign busy        = (state != ST_IDLE);

    assign mem_wr_burst_len  = burst_len;
    assign mem_rd_burst_len  = burst_len;
    assign mem_wr_burst_addr = burst_addr;
    assign mem_rd_burst_addr = burst_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            last_grant       <= SLOT_CH1_RD;
            grant_id         <= SLOT_CH0_WR;
            burst_len        <= '0;
            burst_addr       <= '0;
            mem_wr_burst_req <= 1'b0;
            mem_rd_burst_req <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state            <= ST_ISSUE;
                        last_grant       <= pick_idx;
                        grant_id         <= pick_idx;
                        burst_len        <= pick_len;
                        burst_addr       <= pick_addr;
                        mem_wr_burst_req <= !slot_is_read(pick_idx);
                        mem_rd_burst_req <= slot_is_read(pick_idx);
                    end
                end
                ST_ISSUE: state <= ST_BUSY;
                ST_BUSY: begin
                    if (done) begin
                        state            <= ST_IDLE;
                        mem_wr_burst_req <= 1'b0;
                        mem_rd_burst_req <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_burst_data_req   = '0;
        rd_burst_data_valid = '0;
        wr_burst_finish     = '0;
        rd_burst_finish     = '0;
        if (busy) begin
            if (gnt_rd) rd_burst_data_valid[gnt_ch] = mem_rd_burst_data_valid;
            else        wr_burst_data_req[gnt_ch]   = mem_wr_burst_data_req;
        end
        if (done) begin
            if (gnt_rd) rd_burst_finish[gnt_ch] = 1'b1;
            else        wr_burst_finish[gnt_ch] = 1'b1;
        end
    end

    assign mem_wr_burst_data = gnt_ch ? wr_burst_data[2*MEM_DATA_BITS-1:MEM_DATA_BITS]
                                      : wr_burst_data[MEM_DATA_BITS-1:0];
    assign rd_burst_data     = mem_rd_burst_data;

`ifdef MEM_ARB_WDOG_EN
    // Down-counter reloaded outside BUSY and on every data strobe; hitting zero
    // marks the WDOG_CYCLES-th quiet BUSY cycle.
    localparam logic [15:0] WDOG_LOAD = 16'(WDOG_CYCLES - 1);
    logic [15:0] wdog_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= WDOG_LOAD;
        end else if (state != ST_BUSY || data_strobe || wdog_hit) begin
            wdog_cnt <= WDOG_LOAD;
        end else begin
            wdog_cnt <= wdog_cnt - 16'd1;
        end
    end

    assign wdog_hit    = (state == ST_BUSY) && !data_strobe && (wdog_cnt == 16'd0);
    assign arb_timeout = wdog_hit;
`else
    assign wdog_hit    = 1'b0;
    assign arb_timeout = 1'b0;
`endif

endmodule
